lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, together with rs2 data and the load/store funct3. It runs one word-wide memory bus transaction per request with a req/ack handshake and a timeout. Loads are returned aligned and sign/zero-extended for register writeback; misaligned, illegal-width and timed-out accesses are reported on a one-cycle error strobe.

---
 rtl/lsu.sv | 170 +++++++++++++++++
 tb/tb_lsu.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one word-wide bus transaction per request with req/ack handshake,
// timeout, lane steering for stores and aligned sign/zero-extended load return.
module lsu #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [31:0]          addr_q;
  logic [2:0]           f3_q;
  logic                 store_q;
  logic [4:0]           rd_q;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] load_data;

  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_store && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    case (req_funct3[1:0])
      2'b00:   be_n = 4'b0001 << req_addr[1:0];
      2'b01:   be_n = req_addr[1] ? 4'b1100 : 4'b0011;
      default: be_n = 4'b1111;
    endcase

    wdata_n = '0;
    if (req_store) begin
      case (req_funct3[1:0])
        2'b00:   wdata_n = {4{req_wdata[7:0]}};
        2'b01:   wdata_n = {2{req_wdata[15:0]}};
        default: wdata_n = req_wdata;
      endcase
    end

    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      addr_q    <= '0;
      f3_q      <= '0;
      store_q   <= 1'b0;
      rd_q      <= '0;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
      err_code  <= '0;
      err_addr  <= '0;
    end else begin
      done  <= 1'b0;
      wb_we <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            f3_q      <= req_funct3;
            store_q   <= req_store;
            rd_q      <= req_rd;
            tcnt      <= '0;
            req_ready <= 1'b0;
            if (illegal) begin
              err      <= 1'b1;
              err_code <= 2'b10;
              err_addr <= req_addr;
              state    <= ERR;
            end else if (misaligned) begin
              err      <= 1'b1;
              err_code <= 2'b01;
              err_addr <= req_addr;
              state    <= ERR;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          // ack on the limit cycle takes precedence over the timeout
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            wb_we   <= !store_q && (rd_q != 5'd0);
            if (!store_q) begin
              wb_rd   <= rd_q;
              wb_data <= load_data;
            end
            state <= RESP;
          end else if (tcnt == TIMEOUT_W'(TIMEOUT - 1)) begin
            mem_req  <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b11;
            err_addr <= addr_q;
            state    <= ERR;
          end else begin
            tcnt <= tcnt + TIMEOUT_W'(1);
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        ERR: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, randomized requests against an arithmetic
// reference model, and hand-written timeout and mid-transaction reset sequences.
module tb_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  lsu #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(err), .err_code(err_code), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          ack_delay;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    logic        exp_wbwe;
    logic [31:0] exp_wbdata;
    int          exp_reqcyc;
  } vec_t;

  typedef struct {
    int          n_done;
    int          n_err;
    int          cyc;
    int          reqcyc;
    logic        unstable;
    logic        bad_ready;
    logic        ready_after;
    logic        bad_wbwe;
    logic        wbwe;
    logic [1:0]  code;
    logic [31:0] eaddr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  be;
    logic        we;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [4:0] rd, input int dly, input logic e,
                              input logic [1:0] code, input logic [31:0] maddr,
                              input logic [3:0] be, input logic [31:0] mw, input logic wbwe,
                              input logic [31:0] wbd, input int rc);
    vec_t v;
    v.store = store; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
    v.ack_delay = dly; v.exp_err = e; v.exp_code = code; v.exp_maddr = maddr; v.exp_be = be;
    v.exp_mwdata = mw; v.exp_wbwe = wbwe; v.exp_wbdata = wbd; v.exp_reqcyc = rc;
    return v;
  endfunction

  // Reference model: access size in bytes, alignment by modulo, lanes by byte arithmetic.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    int unsigned size;
    int unsigned off;
    logic [63:0] mask;
    logic [63:0] val;
    logic        legal;
    v = vin;
    v.exp_err = 0; v.exp_code = 0; v.exp_maddr = 0; v.exp_be = 0; v.exp_mwdata = 0;
    v.exp_wbwe = 0; v.exp_wbdata = 0; v.exp_reqcyc = 0;
    legal = v.store ? (v.f3 <= 3'd2) : (v.f3 != 3'd3 && v.f3 != 3'd6 && v.f3 != 3'd7);
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off = v.addr % 4;
    if (!legal) begin
      v.exp_err = 1; v.exp_code = 2'b10;
    end else if ((v.addr % size) != 0) begin
      v.exp_err = 1; v.exp_code = 2'b01;
    end else begin
      v.exp_maddr = v.addr - off;
      v.exp_be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) v.exp_mwdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
      if (v.ack_delay >= int'(TO)) begin
        v.exp_err = 1; v.exp_code = 2'b11; v.exp_reqcyc = TO;
      end else begin
        v.exp_reqcyc = v.ack_delay + 1;
        v.exp_wbwe = !v.store && (v.rd != 0);
        mask = (64'd1 << (8 * size)) - 64'd1;
        val = (64'(v.rdata) >> (8 * off)) & mask;
        if (v.f3[2] == 1'b0 && size < 4 && val[8*size-1]) val = val | ~mask;
        v.exp_wbdata = val[31:0];
      end
    end
    return v;
  endfunction

  task automatic do_txn(input vec_t v, output obs_t o);
    int k;
    int w;
    logic fin;
    o = '{default: 0};
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; req_rd = v.rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom); req_rd = 5'($urandom);
    k = 1;
    fin = 1'b0;
    while (!fin && k <= 40) begin
      if (o.cyc == 0 && req_ready) o.bad_ready = 1'b1;
      if (wb_we && !done) o.bad_wbwe = 1'b1;
      if (mem_req) begin
        o.reqcyc++;
        if (o.reqcyc == 1) begin
          o.maddr = mem_addr; o.be = mem_be; o.we = mem_we; o.mwdata = mem_wdata;
        end else if (mem_addr !== o.maddr || mem_be !== o.be || mem_we !== o.we ||
                     mem_wdata !== o.mwdata) begin
          o.unstable = 1'b1;
        end
      end
      if (done) begin
        o.n_done++;
        if (o.cyc == 0) begin
          o.cyc = k; o.wbwe = wb_we; o.wbrd = wb_rd; o.wbdata = wb_data;
        end
      end
      if (err) begin
        o.n_err++;
        if (o.cyc == 0) begin
          o.cyc = k; o.code = err_code; o.eaddr = err_addr;
        end
      end
      if (o.cyc != 0 && k == o.cyc + 1) begin
        o.ready_after = req_ready;
        fin = 1'b1;
      end else begin
        mem_ack = mem_req && (o.reqcyc == v.ack_delay + 1);
        mem_rdata = mem_ack ? v.rdata : $urandom;
        @(negedge clk);
        k++;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic check_obs(input string tag, input vec_t v, input obs_t o);
    chk({tag, ".err_cnt"}, o.n_err, v.exp_err ? 1 : 0);
    chk({tag, ".done_cnt"}, o.n_done, v.exp_err ? 0 : 1);
    chk({tag, ".latency"}, o.cyc, (v.exp_reqcyc == 0) ? 1 : v.exp_reqcyc + 1);
    chk({tag, ".req_cycles"}, o.reqcyc, v.exp_reqcyc);
    chk({tag, ".busy_ready"}, o.bad_ready, 0);
    chk({tag, ".ready_after"}, o.ready_after, 1);
    chk({tag, ".wbwe_outside"}, o.bad_wbwe, 0);
    if (v.exp_err) begin
      chk({tag, ".err_code"}, o.code, v.exp_code);
      chk({tag, ".err_addr"}, o.eaddr, v.addr);
    end
    if (v.exp_reqcyc > 0) begin
      chk({tag, ".mem_addr"}, o.maddr, v.exp_maddr);
      chk({tag, ".mem_be"}, o.be, v.exp_be);
      chk({tag, ".mem_we"}, o.we, v.store);
      chk({tag, ".stable"}, o.unstable, 0);
      if (v.store) chk({tag, ".mem_wdata"}, o.mwdata, v.exp_mwdata);
    end
    if (!v.exp_err) begin
      chk({tag, ".wb_we"}, o.wbwe, v.exp_wbwe);
      if (v.exp_wbwe) begin
        chk({tag, ".wb_data"}, o.wbdata, v.exp_wbdata);
        chk({tag, ".wb_rd"}, o.wbrd, v.rd);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    vec_t v;
    obs_t o;
    int nd;
    int ne;

    tbl[0]  = mk(0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF11, 5'd5, 0,
                 0, 2'b00, 32'h1000, 4'b1000, 32'h0, 1, 32'hFFFF_FF80, 1);
    tbl[1]  = mk(0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_1234, 5'd7, 3,
                 0, 2'b00, 32'h2000, 4'b1100, 32'h0, 1, 32'h0000_BEEF, 4);
    tbl[2]  = mk(1, 3'b000, 32'h11, 32'h0000_00AB, 32'h0, 5'd3, 0,
                 0, 2'b00, 32'h10, 4'b0010, 32'hABAB_ABAB, 0, 32'h0, 1);
    tbl[3]  = mk(0, 3'b010, 32'h6, 32'h0, 32'h0, 5'd1, 0,
                 1, 2'b01, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0);
    tbl[4]  = mk(1, 3'b100, 32'h40, 32'h1, 32'h0, 5'd1, 0,
                 1, 2'b10, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0);
    tbl[5]  = mk(1, 3'b010, 32'h100, 32'h1234_5678, 32'h0, 5'd0, 1000,
                 1, 2'b11, 32'h100, 4'b1111, 32'h1234_5678, 0, 32'h0, 4);
    tbl[6]  = mk(1, 3'b010, 32'h100, 32'h1234_5678, 32'h0, 5'd0, 3,
                 0, 2'b00, 32'h100, 4'b1111, 32'h1234_5678, 0, 32'h0, 4);
    tbl[7]  = mk(0, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D, 5'd0, 0,
                 0, 2'b00, 32'h20, 4'b1111, 32'h0, 0, 32'h0, 1);
    tbl[8]  = mk(0, 3'b001, 32'h3, 32'h0, 32'h0, 5'd2, 0,
                 1, 2'b01, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0);
    tbl[9]  = mk(0, 3'b011, 32'h0, 32'h0, 32'h0, 5'd2, 0,
                 1, 2'b10, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0);
    tbl[10] = mk(1, 3'b101, 32'h1, 32'h0, 32'h0, 5'd2, 0,
                 1, 2'b10, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0);
    tbl[11] = mk(1, 3'b001, 32'h2, 32'h1234_5678, 32'h0, 5'd4, 1,
                 0, 2'b00, 32'h0, 4'b1100, 32'h5678_5678, 0, 32'h0, 2);
    tbl[12] = mk(0, 3'b001, 32'h8002, 32'h0, 32'h8001_0000, 5'd31, 2,
                 0, 2'b00, 32'h8000, 4'b1100, 32'h0, 1, 32'hFFFF_8001, 3);

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("reset.req_ready", req_ready, 1);
    chk("reset.mem_req", mem_req, 0);
    chk("reset.done", done, 0);
    chk("reset.err", err, 0);
    chk("reset.wb_we", wb_we, 0);
    chk("reset.wb_data", wb_data, 0);
    chk("reset.err_code", err_code, 0);
    chk("reset.mem_be", mem_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      do_txn(tbl[i], o);
      check_obs($sformatf("vec%0d", i), tbl[i], o);
    end

    for (int i = 0; i < 200; i++) begin
      v.store = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.rd = 5'($urandom);
      v.ack_delay = $urandom_range(0, 5);
      v = model(v);
      do_txn(v, o);
      check_obs($sformatf("rnd%0d", i), v, o);
    end

    // Reset pulled while a load waits in the bus phase.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80; req_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.mem_req_before", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid.mem_req", mem_req, 0);
    chk("rstmid.req_ready", req_ready, 1);
    chk("rstmid.done", done, 0);
    chk("rstmid.err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    ne = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (err) ne++;
    end
    chk("rstmid.no_done", nd, 0);
    chk("rstmid.no_err", ne, 0);
    chk("rstmid.ready_after", req_ready, 1);
    chk("rstmid.mem_req_after", mem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
